// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_ADDR_WIDTH   = 12;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam int unsigned CNT_W            = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU (priority) and one peripheral,
// with a starvation counter that forces a one-cycle peripheral grant.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  per_req,
  input  logic                  per_we,
  input  logic [ADDR_WIDTH-1:0] per_addr,
  input  logic [DATA_WIDTH-1:0] per_wdata,
  output logic                  per_ready,
  output logic                  per_rvalid,
  output logic [DATA_WIDTH-1:0] per_rdata,
  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dataIn,
  input  logic [DATA_WIDTH-1:0] ram_dataOut
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             per_grant;
  logic             cpu_grant;
  logic             rd_owner;

  // Grant, RAM mux and starvation bookkeeping; reset suppresses every grant.
  always_comb begin
    per_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      if (state == FORCE && per_req) per_grant = 1'b1;
      else if (cpu_req)              cpu_grant = 1'b1;
      else if (per_req)              per_grant = 1'b1;
    end

    per_ready = per_grant;
    cpu_stall = cpu_req & per_grant;

    if (per_grant) begin
      ram_addr   = per_addr;
      ram_dataIn = per_wdata;
      ram_wEn    = per_we;
    end else begin
      ram_addr   = cpu_addr;
      ram_dataIn = cpu_wdata;
      ram_wEn    = cpu_req & cpu_we & cpu_grant;
    end

    if (per_req && !per_grant)
      cnt_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + CNT_W'(1);
    else
      cnt_nxt = '0;

    if (state == FORCE)        state_nxt = NORMAL;
    else if (cnt_nxt == LIMIT) state_nxt = FORCE;
    else                       state_nxt = NORMAL;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      rd_owner   <= per_grant & ~per_we;
    end
  end

  // Read data is shared; rd_owner marks the cycles that belong to the peripheral.
  assign per_rvalid = rd_owner;
  assign per_rdata  = ram_dataOut;
  assign cpu_rdata  = ram_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        per_req, per_we;
  logic [11:0] per_addr;
  logic [31:0] per_wdata;
  logic        per_ready, per_rvalid;
  logic [31:0] per_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn, ram_dataOut;

  logic [31:0] mem [4096];

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_ready(per_ready), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  typedef struct {
    logic        cr, cw;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        pr, pw;
    logic [11:0] pa;
    logic [31:0] pd;
    logic        wen;
    logic [11:0] addr;
    logic [31:0] din;
    logic        rdy, stall, rv;
    logic        chk_crd;
    logic [31:0] crd;
    logic        chk_prd;
    logic [31:0] prd;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input int cr, cw, ca, input logic [31:0] cd,
    input int pr, pw, pa, input logic [31:0] pd,
    input int wen, addr, input logic [31:0] din,
    input int rdy, stall, rv, chk_crd, input logic [31:0] crd,
    input int chk_prd, input logic [31:0] prd);
    vec_t v;
    v.cr = 1'(cr);   v.cw = 1'(cw);   v.ca = 12'(ca);   v.cd = cd;
    v.pr = 1'(pr);   v.pw = 1'(pw);   v.pa = 12'(pa);   v.pd = pd;
    v.wen = 1'(wen); v.addr = 12'(addr); v.din = din;
    v.rdy = 1'(rdy); v.stall = 1'(stall); v.rv = 1'(rv);
    v.chk_crd = 1'(chk_crd); v.crd = crd;
    v.chk_prd = 1'(chk_prd); v.prd = prd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic cr, cw, input logic [11:0] ca, input logic [31:0] cd,
                      input logic pr, pw, input logic [11:0] pa, input logic [31:0] pd);
    @(negedge clock);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    per_req = pr; per_we = pw; per_addr = pa; per_wdata = pd;
    #1;
  endtask

  initial begin
    logic f;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h020] = 32'h0000CAFE;
    ram_dataOut = 32'h0;

    // Reset with both requesters writing: nothing may be granted.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0AA; cpu_wdata = 32'h1;
    per_req = 1'b1; per_we = 1'b1; per_addr = 12'h0BB; per_wdata = 32'h2;
    #3;
    chk("rst_wen", 32'(ram_wEn), 32'h0);
    chk("rst_ready", 32'(per_ready), 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_rvalid", 32'(per_rvalid), 32'h0);
    @(negedge clock);
    cpu_req = 1'b0; per_req = 1'b0; cpu_we = 1'b0; per_we = 1'b0;
    reset = 1'b0;

    //           cr cw ca      cd            pr pw pa      pd      wen addr    din           rdy st rv ccrd crd           cprd prd
    vecs[0]  = mk(1, 1, 'h010, 32'hDEADBEEF, 0, 0, 'h000, 32'h0,  1, 'h010, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 0, 'h010, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h010, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[2]  = mk(0, 0, 'h000, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h000, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[3]  = mk(0, 0, 'h000, 32'h0,        1, 0, 'h020, 32'h0,  0, 'h020, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[4]  = mk(0, 0, 'h000, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h000, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'h0000CAFE);
    vecs[5]  = mk(0, 0, 'h000, 32'h0,        1, 1, 'h040, 32'h55, 1, 'h040, 32'h55,       1, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[6]  = mk(0, 0, 'h000, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h000, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[7]  = mk(0, 0, 'h000, 32'h0,        1, 0, 'h040, 32'h0,  0, 'h040, 32'h0,        1, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[8]  = mk(0, 0, 'h000, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h000, 32'h0,        0, 0, 1, 0, 32'h0,        1, 32'h55);
    vecs[9]  = mk(1, 0, 'h020, 32'h0,        1, 0, 'h040, 32'h0,  0, 'h020, 32'h0,        0, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[10] = mk(0, 0, 'h000, 32'h0,        0, 0, 'h000, 32'h0,  0, 'h000, 32'h0,        0, 0, 0, 1, 32'h0000CAFE, 0, 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
           vecs[i].pr, vecs[i].pw, vecs[i].pa, vecs[i].pd);
      chk($sformatf("v%0d_wen", i), 32'(ram_wEn), 32'(vecs[i].wen));
      chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_din", i), ram_dataIn, vecs[i].din);
      chk($sformatf("v%0d_ready", i), 32'(per_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d_rvalid", i), 32'(per_rvalid), 32'(vecs[i].rv));
      if (vecs[i].chk_crd) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].crd);
      if (vecs[i].chk_prd) chk($sformatf("v%0d_per_rdata", i), per_rdata, vecs[i].prd);
    end

    // Continuous contention: forced grants in cycles 4 and 9.
    for (int c = 0; c <= 10; c++) begin
      step(1'b1, 1'b0, 12'h100, 32'h0, 1'(c < 10), 1'b0, 12'h020, 32'h0);
      f = 1'(c == 4 || c == 9);
      chk($sformatf("contA_c%0d_ready", c), 32'(per_ready), 32'(f));
      chk($sformatf("contA_c%0d_stall", c), 32'(cpu_stall), 32'(f));
      chk($sformatf("contA_c%0d_addr", c), 32'(ram_addr), f ? 32'h020 : 32'h100);
      chk($sformatf("contA_c%0d_rvalid", c), 32'(per_rvalid), 32'(c == 5 || c == 10));
      if (c == 5 || c == 10) chk($sformatf("contA_c%0d_rdata", c), per_rdata, 32'h0000CAFE);
    end

    // Peripheral withdraws in the FORCE cycle; CPU write proceeds, counter restarts.
    for (int c = 0; c <= 9; c++) begin
      if (c == 4) step(1'b1, 1'b1, 12'h050, 32'hA5A5A5A5, 1'b0, 1'b0, 12'h020, 32'h0);
      else        step(1'b1, 1'b0, 12'h100, 32'h0,        1'b1, 1'b0, 12'h020, 32'h0);
      chk($sformatf("wd_c%0d_ready", c), 32'(per_ready), 32'(c == 9));
      chk($sformatf("wd_c%0d_stall", c), 32'(cpu_stall), 32'(c == 9));
      if (c == 4) begin
        chk("wd_force_wen", 32'(ram_wEn), 32'h1);
        chk("wd_force_addr", 32'(ram_addr), 32'h050);
      end
    end
    step(1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("wd_rvalid", 32'(per_rvalid), 32'h1);
    chk("wd_per_rdata", per_rdata, 32'h0000CAFE);
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("wd_cpu_rdata", cpu_rdata, 32'hA5A5A5A5);

    // Peripheral write wins the forced cycle; the stalled CPU write is dropped.
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) step(1'b1, 1'b1, 12'(12'h060 + c), 32'(c), 1'b1, 1'b1, 12'h030, 32'h12345678);
      else       step(1'b1, 1'b1, 12'h070, 32'h77,          1'b1, 1'b1, 12'h030, 32'h12345678);
      chk($sformatf("pw_c%0d_ready", c), 32'(per_ready), 32'(c == 4));
      chk($sformatf("pw_c%0d_wen", c), 32'(ram_wEn), 32'h1);
      chk($sformatf("pw_c%0d_addr", c), 32'(ram_addr), (c == 4) ? 32'h030 : 32'(12'h060 + c));
      chk($sformatf("pw_c%0d_din", c), ram_dataIn, (c == 4) ? 32'h12345678 : 32'(c));
    end
    chk("pw_force_stall", 32'(cpu_stall), 32'h1);
    step(1'b1, 1'b0, 12'h030, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("pw_rvalid", 32'(per_rvalid), 32'h0);
    step(1'b1, 1'b0, 12'h070, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("pw_rd030", cpu_rdata, 32'h12345678);
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("pw_rd070", cpu_rdata, 32'h0);

    // Asynchronous reset in the FORCE cycle, then a full count of denials again.
    for (int c = 0; c <= 4; c++) begin
      step(1'b1, 1'b0, 12'h100, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
      chk($sformatf("rf_c%0d_ready", c), 32'(per_ready), 32'(c == 4));
    end
    chk("rf_force_stall", 32'(cpu_stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("rf_rst_ready", 32'(per_ready), 32'h0);
    chk("rf_rst_stall", 32'(cpu_stall), 32'h0);
    chk("rf_rst_rvalid", 32'(per_rvalid), 32'h0);
    chk("rf_rst_wen", 32'(ram_wEn), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      step(1'b1, 1'b0, 12'h100, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
      chk($sformatf("ra_c%0d_ready", c), 32'(per_ready), 32'(c == 4));
      chk($sformatf("ra_c%0d_stall", c), 32'(cpu_stall), 32'(c == 4));
      if (c == 0) chk("ra_rvalid", 32'(per_rvalid), 32'h0);
    end
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    chk("ra_final_rvalid", 32'(per_rvalid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
